ground_scroll_ctrl: RTL and testbench

GROUND_SCROLL_CTRL -- requirements
Module: ground_scroll_ctrl

---
 rtl/ground_scroll_ctrl.sv | 134 +++++++++++++
 tb/tb_ground_scroll_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ground_scroll_ctrl.sv
// ground_scroll_ctrl: scrolling ground band renderer for a VGA endless-runner.
// Detects the frame boundary from vs, runs an IDLE/RUN/PAUSED controller that
// advances the horizontal scroll offset once per RUN frame with a stepped
// speed ramp, and renders a registered ground pixel from row/column.
//
// Ports:
//   vga_clk       in   pixel clock, all state changes on its rising edge
//   clr           in   asynchronous active-high reset
//   run           in   1 = game running, 0 = return to IDLE (sampled at frame boundary)
//   pause         in   1 = freeze scrolling while running (sampled at frame boundary)
//   vs            in   vertical sync, low during the first two lines
//   rdn           in   active-low pixel read strobe
//   row_addr      in   current pixel row (9b)
//   col_addr      in   current pixel column (10b)
//   px_ground     out  ground pixel, 1 = black (registered, 1-cycle latency)
//   scroll_offset out  horizontal scroll offset (10b)
//   speed         out  scroll step in pixels per frame (4b)
//   frame_cnt     out  RUN frame counter (16b)
//   state         out  00 IDLE, 01 RUN, 10 PAUSED
module ground_scroll_ctrl #(
  parameter logic [8:0] GROUND_TOP      = 9'd400,
  parameter logic [3:0] SPEED_INIT      = 4'd2,
  parameter logic [3:0] SPEED_MAX       = 4'd8,
  parameter logic [7:0] FRAMES_PER_STEP = 8'd120
) (
  input  logic        vga_clk,
  input  logic        clr,
  input  logic        run,
  input  logic        pause,
  input  logic        vs,
  input  logic        rdn,
  input  logic [8:0]  row_addr,
  input  logic [9:0]  col_addr,
  output logic        px_ground,
  output logic [9:0]  scroll_offset,
  output logic [3:0]  speed,
  output logic [15:0] frame_cnt,
  output logic [1:0]  state
);

  localparam int unsigned OFF_W  = 10;
  localparam int unsigned ROW_W  = 10;
  localparam int unsigned STEP_W = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_PAUSED = 2'b10
  } state_e;

  state_e              state_q, state_d;
  logic                vs_q;
  logic [OFF_W-1:0]    offset_q;
  logic [3:0]          speed_q;
  logic [15:0]         frame_q;
  logic [STEP_W-1:0]   step_q;
  logic                px_q;

  logic                fb_c;
  logic                upd_c;
  logic                px_d;
  logic [1:0]          stripe_c;
  logic [ROW_W-1:0]    row_c;
  logic [ROW_W-1:0]    top_c;

  // Frame boundary: vs seen low while its registered copy is still high.
  always_comb begin
    fb_c    = vs_q & ~vs;
    state_d = state_q;
    if (fb_c) begin
      if (!run)      state_d = S_IDLE;
      else if (pause) state_d = S_PAUSED;
      else            state_d = S_RUN;
    end
    upd_c = fb_c && (state_q == S_RUN) && (state_d == S_RUN);
  end

  // Ground pixel: solid band of 8 rows, then a 4-row dashed lip whose dash
  // pattern (8 on, 24 off) moves with the scroll offset.
  always_comb begin
    row_c    = ROW_W'(row_addr);
    top_c    = ROW_W'(GROUND_TOP);
    stripe_c = 2'((col_addr[4:0] + scroll_offset[4:0]) >> 3);
    px_d     = 1'b0;
    if (!rdn) begin
      if (row_c >= top_c && row_c < top_c + ROW_W'(8))
        px_d = 1'b1;
      else if (row_c >= top_c + ROW_W'(8) && row_c < top_c + ROW_W'(12) && stripe_c == 2'b00)
        px_d = 1'b1;
    end
  end

  // Controller, scroll counters and pixel register.
  always_ff @(posedge vga_clk or posedge clr) begin
    if (clr) begin
      state_q  <= S_IDLE;
      vs_q     <= 1'b1;
      offset_q <= '0;
      speed_q  <= SPEED_INIT;
      frame_q  <= '0;
      step_q   <= '0;
      px_q     <= 1'b0;
    end else begin
      vs_q <= vs;
      px_q <= px_d;
      if (fb_c) begin
        state_q <= state_d;
        if (state_d == S_IDLE) begin
          offset_q <= '0;
          speed_q  <= SPEED_INIT;
          frame_q  <= '0;
          step_q   <= '0;
        end else if (upd_c) begin
          offset_q <= offset_q + OFF_W'(speed_q);
          frame_q  <= frame_q + 16'd1;
          // Speed bump takes effect for the offset update at the next boundary.
          if (step_q == FRAMES_PER_STEP - 8'd1) begin
            step_q <= '0;
            if (speed_q < SPEED_MAX) speed_q <= speed_q + 4'd1;
          end else begin
            step_q <= step_q + 8'd1;
          end
        end
      end
    end
  end

  assign state         = state_q;
  assign scroll_offset = offset_q;
  assign speed         = speed_q;
  assign frame_cnt     = frame_q;
  assign px_ground     = px_q;

endmodule

// File: tb/tb_ground_scroll_ctrl.sv
// Bench for ground_scroll_ctrl: directed pixel table, directed frame sequences
// and randomized frames, all compared each cycle against a frame-level model.
module tb_ground_scroll_ctrl;

  localparam int FPS  = 4;
  localparam int INIT = 2;
  localparam int SMAX = 8;
  localparam int GT   = 400;

  logic        vga_clk = 1'b0;
  logic        clr, run, pause, vs, rdn;
  logic [8:0]  row_addr;
  logic [9:0]  col_addr;
  logic        px_ground;
  logic [9:0]  scroll_offset;
  logic [3:0]  speed;
  logic [15:0] frame_cnt;
  logic [1:0]  state;

  ground_scroll_ctrl #(
    .GROUND_TOP(9'd400), .SPEED_INIT(4'd2), .SPEED_MAX(4'd8), .FRAMES_PER_STEP(8'd4)
  ) dut (
    .vga_clk(vga_clk), .clr(clr), .run(run), .pause(pause), .vs(vs), .rdn(rdn),
    .row_addr(row_addr), .col_addr(col_addr), .px_ground(px_ground),
    .scroll_offset(scroll_offset), .speed(speed), .frame_cnt(frame_cnt), .state(state)
  );

  always #20 vga_clk = ~vga_clk;

  int checks = 0;
  int errors = 0;
  bit rand_pix = 0;

  // Model: frame-level game state. Speed and frame count derive from the
  // number of RUN->RUN updates since the last return to IDLE.
  int m_state, m_off, m_upd, m_px, m_prev_vs;

  function automatic int m_speed();
    int s;
    s = INIT + m_upd / FPS;
    return (s > SMAX) ? SMAX : s;
  endfunction

  function automatic void m_reset();
    m_state = 0; m_off = 0; m_upd = 0; m_px = 0; m_prev_vs = 1;
  endfunction

  function automatic void m_step();
    int r, u, ns, pxn;
    r   = int'(row_addr);
    u   = (int'(col_addr) + m_off) % 1024;
    pxn = 0;
    if (!rdn) begin
      if (r >= GT && r < GT + 8) pxn = 1;
      else if (r >= GT + 8 && r < GT + 12 && ((u / 8) % 4) == 0) pxn = 1;
    end
    if (m_prev_vs == 1 && vs == 1'b0) begin
      ns = !run ? 0 : (pause ? 2 : 1);
      if (ns == 0) begin
        m_off = 0; m_upd = 0;
      end else if (m_state == 1 && ns == 1) begin
        m_off = (m_off + m_speed()) % 1024;
        m_upd++;
      end
      m_state = ns;
    end
    m_prev_vs = int'(vs);
    m_px = pxn;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic check_all();
    chk("state",  int'(state),         m_state);
    chk("offset", int'(scroll_offset), m_off);
    chk("speed",  int'(speed),         m_speed());
    chk("frames", int'(frame_cnt),     m_upd % 65536);
    chk("px",     int'(px_ground),     m_px);
  endtask

  task automatic tick();
    if (rand_pix) begin
      row_addr = 9'($urandom_range(395, 415));
      col_addr = 10'($urandom_range(0, 1023));
      rdn      = ($urandom_range(0, 3) == 0);
    end
    @(posedge vga_clk);
    if (!clr) m_step();
    @(negedge vga_clk);
    check_all();
  endtask

  task automatic frame(input int hi);
    vs = 1'b0;
    tick(); tick();
    vs = 1'b1;
    for (int i = 0; i < hi; i++) tick();
  endtask

  typedef struct {
    int row;
    int col;
    bit rdn;
    bit px;
  } pix_vec_t;

  pix_vec_t tbl[11];
  int saved_off, saved_spd, saved_frm;

  initial begin
    tbl[0]  = '{400, 5,    1'b0, 1'b1};
    tbl[1]  = '{408, 8,    1'b0, 1'b0};
    tbl[2]  = '{408, 33,   1'b0, 1'b1};
    tbl[3]  = '{400, 5,    1'b1, 1'b0};
    tbl[4]  = '{399, 0,    1'b0, 1'b0};
    tbl[5]  = '{407, 100,  1'b0, 1'b1};
    tbl[6]  = '{411, 0,    1'b0, 1'b1};
    tbl[7]  = '{412, 0,    1'b0, 1'b0};
    tbl[8]  = '{411, 24,   1'b0, 1'b0};
    tbl[9]  = '{409, 1023, 1'b0, 1'b0};
    tbl[10] = '{410, 7,    1'b0, 1'b1};

    // Reset state
    clr = 1'b1; run = 1'b0; pause = 1'b0; vs = 1'b1; rdn = 1'b1;
    row_addr = '0; col_addr = '0;
    m_reset();
    repeat (3) @(negedge vga_clk);
    check_all();
    chk("rst_speed", int'(speed), 2);
    chk("rst_state", int'(state), 0);
    clr = 1'b0;

    // Pixel table at offset 0 (IDLE, vs held high)
    for (int i = 0; i < 11; i++) begin
      row_addr = 9'(tbl[i].row);
      col_addr = 10'(tbl[i].col);
      rdn      = tbl[i].rdn;
      tick();
      chk("pix_tbl", int'(px_ground), int'(tbl[i].px));
    end
    rdn = 1'b1;

    // Start: RUN after fb1, first update at fb2
    run = 1'b1;
    frame(6);
    chk("start_state", int'(state), 1);
    chk("start_off0", int'(scroll_offset), 0);
    frame(6); frame(6);
    chk("start_off", int'(scroll_offset), 4);
    chk("start_frames", int'(frame_cnt), 2);

    // Speed ramp to saturation
    rand_pix = 1;
    for (int i = 0; i < 30; i++) frame(4);
    chk("ramp_sat", int'(speed), 8);

    // Pause freezes everything, resume continues from same values
    saved_off = int'(scroll_offset); saved_spd = int'(speed); saved_frm = int'(frame_cnt);
    pause = 1'b1;
    for (int i = 0; i < 5; i++) frame(4);
    chk("pause_state", int'(state), 2);
    chk("pause_off", int'(scroll_offset), saved_off);
    chk("pause_frm", int'(frame_cnt), saved_frm);
    pause = 1'b0;
    frame(4);
    chk("resume_state", int'(state), 1);
    chk("resume_off", int'(scroll_offset), saved_off);
    frame(4);
    chk("resume_step", int'(scroll_offset), (saved_off + saved_spd) % 1024);

    // Long run at max speed: offset wraps several times
    for (int i = 0; i < 140; i++) frame(3);
    chk("wrap_off", int'(scroll_offset), (saved_off + 8 + 140 * 8) % 1024);
    chk("wrap_frm", int'(frame_cnt), saved_frm + 141);

    // Randomized frames
    for (int i = 0; i < 120; i++) begin
      run   = ($urandom_range(0, 7) != 0);
      pause = ($urandom_range(0, 3) == 0);
      frame($urandom_range(3, 8));
    end

    // clr mid-line while running
    run = 1'b1; pause = 1'b0;
    frame(4); frame(4); frame(4);
    tick(); tick();
    #3 clr = 1'b1;
    #1;
    m_reset();
    chk("clr_state", int'(state), 0);
    chk("clr_off", int'(scroll_offset), 0);
    chk("clr_speed", int'(speed), 2);
    chk("clr_frames", int'(frame_cnt), 0);
    chk("clr_px", int'(px_ground), 0);
    vs = 1'b0;
    tick(); tick();
    chk("clr_hold", int'(state), 0);
    clr = 1'b0;
    tick();
    chk("clr_first_fb", int'(state), 1);
    vs = 1'b1;
    tick(); tick();
    frame(4); frame(4);

    // run=0 with pause=1 returns to IDLE and clears
    run = 1'b0; pause = 1'b1;
    frame(4);
    chk("idle_state", int'(state), 0);
    chk("idle_off", int'(scroll_offset), 0);
    chk("idle_frames", int'(frame_cnt), 0);
    chk("idle_speed", int'(speed), 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
